seg7_message_sequencer: RTL and testbench



---
 rtl/seg7_message_sequencer_if.sv | 25 ++
 rtl/seg7_message_sequencer.sv | 158 +++++++++++++++
 tb/tb_seg7_message_sequencer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/seg7_message_sequencer_if.sv
// Write port, message control and display outputs of the 7-segment message sequencer.
// The master side drives commands and buffer writes; the slave side is the sequencer.
interface seg7_message_sequencer_if;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [4:0] wr_code;
    logic       start;
    logic [2:0] len;
    logic       loop;
    logic       stop;
    logic [7:0] seg_n;
    logic       busy;
    logic       done;
    logic [2:0] cur_idx;

    modport master (
        output wr_en, wr_addr, wr_code, start, len, loop, stop,
        input  seg_n, busy, done, cur_idx
    );

    modport slave (
        input  wr_en, wr_addr, wr_code, start, len, loop, stop,
        output seg_n, busy, done, cur_idx
    );
endinterface

// File: rtl/seg7_message_sequencer.sv
// Steps an 8-entry character buffer onto one active-low 7-segment digit,
// alternating each glyph with an equal-length blank gap.
module seg7_message_sequencer #(
    parameter int unsigned DWELL = 32'd4194304,
    parameter int unsigned CW    = 32'd24
) (
    input  logic                     clk,
    input  logic                     reset,
    seg7_message_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 32'd1);

    state_t        state_r;
    logic [2:0]    idx_r;
    logic [CW-1:0] cnt_r;
    logic [2:0]    len_q_r;
    logic          loop_q_r;
    logic          done_evt_r;
    logic [4:0]    code_buf_r [8];

    logic [7:0]    seg_n_r;
    logic          busy_r;
    logic          done_r;
    logic [2:0]    cur_idx_r;

    // Character code to active-low segment pattern (xGFEDCBA, DP kept dark).
    function automatic logic [7:0] glyph(input logic [4:0] code);
        logic [7:0] g;
        case (code)
            5'h00:   g = 8'hFF;
            5'h01:   g = 8'h89;
            5'h02:   g = 8'h86;
            5'h03:   g = 8'hC7;
            5'h04:   g = 8'hC0;
            5'h05:   g = 8'h88;
            5'h06:   g = 8'h92;
            5'h07:   g = 8'hCF;
            5'h08:   g = 8'hC6;
            5'h10:   g = 8'hC0;
            5'h11:   g = 8'hF9;
            5'h12:   g = 8'hA4;
            5'h13:   g = 8'hB0;
            5'h14:   g = 8'h99;
            5'h15:   g = 8'h92;
            5'h16:   g = 8'h82;
            5'h17:   g = 8'hF8;
            5'h18:   g = 8'h80;
            5'h19:   g = 8'h90;
            default: g = 8'hFF;
        endcase
        return g;
    endfunction

    // Code buffer: writes are accepted in every state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                code_buf_r[i] <= 5'd0;
            end
        end else if (bus.wr_en) begin
            code_buf_r[bus.wr_addr] <= bus.wr_code;
        end else begin
            code_buf_r[bus.wr_addr] <= code_buf_r[bus.wr_addr];
        end
    end

    // Sequencing FSM; stop overrides every other transition and suppresses done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            idx_r      <= 3'd0;
            cnt_r      <= '0;
            len_q_r    <= 3'd0;
            loop_q_r   <= 1'b0;
            done_evt_r <= 1'b0;
        end else begin
            done_evt_r <= 1'b0;
            if (bus.stop) begin
                state_r <= ST_IDLE;
                idx_r   <= 3'd0;
                cnt_r   <= '0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (bus.start) begin
                            state_r  <= ST_SHOW;
                            idx_r    <= 3'd0;
                            cnt_r    <= '0;
                            len_q_r  <= bus.len;
                            loop_q_r <= bus.loop;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_SHOW: begin
                        if (cnt_r == CNT_LAST) begin
                            state_r <= ST_GAP;
                            cnt_r   <= '0;
                        end else begin
                            cnt_r <= cnt_r + CW'(1);
                        end
                    end
                    ST_GAP: begin
                        if (cnt_r != CNT_LAST) begin
                            cnt_r <= cnt_r + CW'(1);
                        end else if (idx_r < len_q_r) begin
                            state_r <= ST_SHOW;
                            idx_r   <= idx_r + 3'd1;
                            cnt_r   <= '0;
                        end else if (loop_q_r) begin
                            state_r <= ST_SHOW;
                            idx_r   <= 3'd0;
                            cnt_r   <= '0;
                        end else begin
                            state_r    <= ST_IDLE;
                            idx_r      <= 3'd0;
                            cnt_r      <= '0;
                            done_evt_r <= 1'b1;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        idx_r   <= 3'd0;
                        cnt_r   <= '0;
                    end
                endcase
            end
        end
    end

    // Output registers track the FSM one cycle behind; the glyph is re-read each cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_n_r   <= 8'hFF;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            cur_idx_r <= 3'd0;
        end else begin
            seg_n_r   <= (state_r == ST_SHOW) ? glyph(code_buf_r[idx_r]) : 8'hFF;
            busy_r    <= (state_r != ST_IDLE);
            done_r    <= done_evt_r;
            cur_idx_r <= idx_r;
        end
    end

    assign bus.seg_n   = seg_n_r;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.cur_idx = cur_idx_r;

endmodule

// File: tb/tb_seg7_message_sequencer.sv
// Directed bench for seg7_message_sequencer with DWELL=4: decode table sweep plus
// hand-written message, loop, stop, live-write and asynchronous reset sequences.
module tb_seg7_message_sequencer;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    seg7_message_sequencer_if bus ();

    seg7_message_sequencer #(.DWELL(32'd4), .CW(32'd3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] code;
        logic [7:0] seg;
    } dec_vec_t;

    dec_vec_t   vec [32];
    logic [7:0] hello_seg [5];
    logic [7:0] digit_seg [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] addr, input logic [4:0] code);
        bus.wr_en   = 1'b1;
        bus.wr_addr = addr;
        bus.wr_code = code;
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic go(input logic [2:0] l, input logic lp);
        bus.start = 1'b1;
        bus.len   = l;
        bus.loop  = lp;
        tick();
        bus.start = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_seg;
        int         ph;
        n_cmp = 0;
        n_err = 0;
        bus.wr_en = 1'b0; bus.wr_addr = 3'd0; bus.wr_code = 5'd0;
        bus.start = 1'b0; bus.len = 3'd0; bus.loop = 1'b0; bus.stop = 1'b0;

        for (int i = 0; i < 32; i++) begin
            vec[i].code = 5'(i);
            vec[i].seg  = 8'hFF;
        end
        vec[1].seg  = 8'h89; vec[2].seg  = 8'h86; vec[3].seg  = 8'hC7; vec[4].seg  = 8'hC0;
        vec[5].seg  = 8'h88; vec[6].seg  = 8'h92; vec[7].seg  = 8'hCF; vec[8].seg  = 8'hC6;
        vec[16].seg = 8'hC0; vec[17].seg = 8'hF9; vec[18].seg = 8'hA4; vec[19].seg = 8'hB0;
        vec[20].seg = 8'h99; vec[21].seg = 8'h92; vec[22].seg = 8'h82; vec[23].seg = 8'hF8;
        vec[24].seg = 8'h80; vec[25].seg = 8'h90;
        hello_seg = '{8'h89, 8'h86, 8'hC7, 8'hC7, 8'hC0};
        digit_seg = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};

        // Reset state
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_seg", 32'(bus.seg_n), 32'hFF);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_idx", 32'(bus.cur_idx), 32'd0);
        tick();
        check("idle_seg", 32'(bus.seg_n), 32'hFF);
        check("idle_busy", 32'(bus.busy), 32'd0);

        // Decode sweep over every code
        for (int i = 0; i < 32; i++) begin
            wr(3'd0, vec[i].code);
            go(3'd0, 1'b0);
            tick();
            check($sformatf("dec_%0h", vec[i].code), 32'(bus.seg_n), 32'(vec[i].seg));
            check($sformatf("dec_dp_%0h", vec[i].code), 32'(bus.seg_n[7]), 32'd1);
            bus.stop = 1'b1;
            tick();
            bus.stop = 1'b0;
            tick();
        end

        // HELLO, with a start/len/loop pulse while busy that must be ignored
        wr(3'd0, 5'h01); wr(3'd1, 5'h02); wr(3'd2, 5'h03); wr(3'd3, 5'h03); wr(3'd4, 5'h04);
        go(3'd4, 1'b0);
        for (int k = 1; k <= 44; k++) begin
            tick();
            ph = (k - 1) / 4;
            exp_seg = (k <= 40 && (ph % 2) == 0) ? hello_seg[ph / 2] : 8'hFF;
            check($sformatf("hello_seg_k%0d", k), 32'(bus.seg_n), 32'(exp_seg));
            check($sformatf("hello_busy_k%0d", k), 32'(bus.busy), (k <= 40) ? 32'd1 : 32'd0);
            check($sformatf("hello_done_k%0d", k), 32'(bus.done), (k == 41) ? 32'd1 : 32'd0);
            if (k <= 40) check($sformatf("hello_idx_k%0d", k), 32'(bus.cur_idx), 32'((k - 1) / 8));
            bus.start = (k == 10);
            bus.len   = (k == 10) ? 3'd0 : 3'd4;
            bus.loop  = (k == 10);
        end
        bus.start = 1'b0; bus.loop = 1'b0;

        // Loop message, then stop
        wr(3'd0, 5'h05);
        go(3'd0, 1'b1);
        for (int k = 1; k <= 40; k++) begin
            tick();
            exp_seg = (((k - 1) / 4) % 2 == 0) ? 8'h88 : 8'hFF;
            check($sformatf("loop_seg_k%0d", k), 32'(bus.seg_n), 32'(exp_seg));
            check($sformatf("loop_busy_k%0d", k), 32'(bus.busy), 32'd1);
            check($sformatf("loop_done_k%0d", k), 32'(bus.done), 32'd0);
        end
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check($sformatf("stop_seg_k%0d", k), 32'(bus.seg_n), 32'hFF);
            check($sformatf("stop_busy_k%0d", k), 32'(bus.busy), 32'd0);
            check($sformatf("stop_done_k%0d", k), 32'(bus.done), 32'd0);
        end

        // start and stop together in IDLE
        bus.start = 1'b1; bus.stop = 1'b1;
        tick();
        bus.start = 1'b0; bus.stop = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check($sformatf("ss_busy_k%0d", k), 32'(bus.busy), 32'd0);
            check($sformatf("ss_seg_k%0d", k), 32'(bus.seg_n), 32'hFF);
        end

        // Full 8-character message
        for (int a = 0; a < 8; a++) wr(3'(a), 5'(16 + a));
        go(3'd7, 1'b0);
        for (int k = 1; k <= 66; k++) begin
            tick();
            ph = (k - 1) / 4;
            exp_seg = (k <= 64 && (ph % 2) == 0) ? digit_seg[ph / 2] : 8'hFF;
            check($sformatf("len7_seg_k%0d", k), 32'(bus.seg_n), 32'(exp_seg));
            check($sformatf("len7_busy_k%0d", k), 32'(bus.busy), (k <= 64) ? 32'd1 : 32'd0);
            check($sformatf("len7_done_k%0d", k), 32'(bus.done), (k == 65) ? 32'd1 : 32'd0);
            if (k <= 64) check($sformatf("len7_idx_k%0d", k), 32'(bus.cur_idx), 32'((k - 1) / 8));
        end

        // Live write into the entry being shown
        wr(3'd0, 5'h01); wr(3'd1, 5'h02);
        go(3'd1, 1'b0);
        for (int k = 1; k <= 18; k++) begin
            tick();
            if (k <= 4)       exp_seg = 8'h89;
            else if (k <= 8)  exp_seg = 8'hFF;
            else if (k <= 10) exp_seg = 8'h86;
            else if (k <= 12) exp_seg = 8'hF8;
            else              exp_seg = 8'hFF;
            check($sformatf("live_seg_k%0d", k), 32'(bus.seg_n), 32'(exp_seg));
            check($sformatf("live_done_k%0d", k), 32'(bus.done), (k == 17) ? 32'd1 : 32'd0);
            bus.wr_en   = (k == 9);
            bus.wr_addr = 3'd1;
            bus.wr_code = 5'h17;
        end
        bus.wr_en = 1'b0;

        // Asynchronous reset during SHOW of index 1
        wr(3'd1, 5'h02);
        go(3'd1, 1'b0);
        repeat (10) tick();
        check("ar_pre_idx", 32'(bus.cur_idx), 32'd1);
        check("ar_pre_seg", 32'(bus.seg_n), 32'h86);
        #3 reset = 1'b1;
        #1;
        check("ar_seg", 32'(bus.seg_n), 32'hFF);
        check("ar_busy", 32'(bus.busy), 32'd0);
        check("ar_idx", 32'(bus.cur_idx), 32'd0);
        #2 reset = 1'b0;
        go(3'd0, 1'b0);
        tick();
        check("ar_post_busy", 32'(bus.busy), 32'd1);
        check("ar_post_seg", 32'(bus.seg_n), 32'hFF);
        tick();
        check("ar_post_seg2", 32'(bus.seg_n), 32'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
